// File: rtl/gb_channel_router.sv
// Purpose: fans one host ghostbus out to NCH equal address windows and holds a 4-word local CSR bank.
// Latency: channel strobes 1 cycle after the host strobe; every read returns RD_LAT+2 cycles after issue.
// Backpressure: none; one access per cycle is accepted and returned in issue order with no stalls.
//
// Ports:
//   gb_clk, gb_rst          clock, synchronous active-high reset
//   gb_addr/gb_wdata        host address and write data
//   gb_wen/gb_rstb          host single-cycle write / read strobes (write wins when both are high)
//   gb_rdata/gb_rvalid      read return data and its one-cycle qualifier
//   ch_addr/ch_wdata        registered window-relative address and write data, shared by all channels
//   ch_we/ch_rstb           per-channel one-hot write / read strobes
//   ch_rdata                channel read data, channel k at [(k+1)*DW-1 -: DW]
module gb_channel_router #(
  parameter int              AW         = 24,
  parameter int              DW         = 32,
  parameter int              NCH        = 4,
  parameter int              CH_AW      = 8,
  parameter logic [AW-1:0]   BASE       = 24'h000100,
  parameter logic [AW-1:0]   LOCAL_BASE = 24'h000000,
  parameter int              RD_LAT     = 2,
  parameter logic [DW-1:0]   MISS_DATA  = 32'hDEADBEEF
) (
  input  logic                gb_clk,
  input  logic                gb_rst,
  input  logic [AW-1:0]       gb_addr,
  input  logic [DW-1:0]       gb_wdata,
  input  logic                gb_wen,
  input  logic                gb_rstb,
  output logic [DW-1:0]       gb_rdata,
  output logic                gb_rvalid,
  output logic [AW-1:0]       ch_addr,
  output logic [DW-1:0]       ch_wdata,
  output logic [NCH-1:0]      ch_we,
  output logic [NCH-1:0]      ch_rstb,
  input  logic [NCH*DW-1:0]   ch_rdata
);

  localparam int              HIW     = AW - CH_AW;
  localparam int              IDXW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [HIW-1:0]  BASE_HI = BASE[AW-1:CH_AW];
  localparam logic [DW-1:0]   ID_WORD = DW'({8'h47, 8'(NCH), 8'(CH_AW), 8'(RD_LAT)});

  // Local CSR state
  logic [NCH-1:0]  ch_en;
  logic [15:0]     miss_cnt;
  logic [AW-1:0]   miss_addr;

  // Decode
  logic [NCH-1:0]  hit;
  logic [IDXW-1:0] hit_idx;
  logic            local_hit;
  logic            op_wr;
  logic            op_rd;
  logic            any_op;
  logic            miss;
  logic [DW-1:0]   local_rdata;

  // Only enabled windows decode as hits, so a disabled window falls through to miss.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_en[k] && (gb_addr[AW-1:CH_AW] == BASE_HI + HIW'(k))) begin
        hit[k]  = 1'b1;
        hit_idx = IDXW'(k);
      end
    end
  end

  assign local_hit = (gb_addr[AW-1:2] == LOCAL_BASE[AW-1:2]);
  assign op_wr     = gb_wen;
  assign op_rd     = gb_rstb & ~gb_wen;   // a simultaneous read is dropped
  assign any_op    = gb_wen | gb_rstb;
  assign miss      = any_op & ~local_hit & ~(|hit);

  // Snapshot of the CSR bank as it stands in the issue cycle.
  always_comb begin
    local_rdata = '0;
    case (gb_addr[1:0])
      2'd0:    local_rdata = DW'(ch_en);
      2'd1:    local_rdata = DW'(miss_cnt);
      2'd2:    local_rdata = DW'(miss_addr);
      default: local_rdata = ID_WORD;
    endcase
  end

  // CSR bank; a MISS_CNT write takes priority over a concurrent miss increment.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      ch_en     <= '1;
      miss_cnt  <= '0;
      miss_addr <= '0;
    end else begin
      if (op_wr && local_hit && (gb_addr[1:0] == 2'd0)) begin
        ch_en <= gb_wdata[NCH-1:0];
      end
      if (op_wr && local_hit && (gb_addr[1:0] == 2'd1)) begin
        miss_cnt <= '0;
      end else if (miss && (miss_cnt != 16'hFFFF)) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
      if (miss) begin
        miss_addr <= gb_addr;
      end
    end
  end

  // Issue stage; addr/wdata hold between strobes.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      ch_addr  <= '0;
      ch_wdata <= '0;
      ch_we    <= '0;
      ch_rstb  <= '0;
    end else begin
      ch_we   <= hit & {NCH{op_wr}};
      ch_rstb <= hit & {NCH{op_rd}};
      if (any_op) begin
        ch_addr  <= {{HIW{1'b0}}, gb_addr[CH_AW-1:0]};
        ch_wdata <= gb_wdata;
      end
    end
  end

  // Read return pipeline: stage j corresponds to cycle T+1+j, so the last
  // stage lines up with the cycle in which channel data is valid.
  logic            p_vld [RD_LAT+1];
  logic            p_ch  [RD_LAT+1];
  logic [IDXW-1:0] p_idx [RD_LAT+1];
  logic [DW-1:0]   p_dat [RD_LAT+1];

  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      for (int j = 0; j <= RD_LAT; j++) begin
        p_vld[j] <= 1'b0;
        p_ch[j]  <= 1'b0;
        p_idx[j] <= '0;
        p_dat[j] <= '0;
      end
    end else begin
      p_vld[0] <= op_rd;
      p_ch[0]  <= |hit;
      p_idx[0] <= hit_idx;
      p_dat[0] <= local_hit ? local_rdata : MISS_DATA;
      for (int j = 1; j <= RD_LAT; j++) begin
        p_vld[j] <= p_vld[j-1];
        p_ch[j]  <= p_ch[j-1];
        p_idx[j] <= p_idx[j-1];
        p_dat[j] <= p_dat[j-1];
      end
    end
  end

  logic [DW-1:0] ret_ch_dat;

  always_comb begin
    ret_ch_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (p_idx[RD_LAT] == IDXW'(k)) begin
        ret_ch_dat = ch_rdata[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      gb_rvalid <= 1'b0;
      gb_rdata  <= '0;
    end else begin
      gb_rvalid <= p_vld[RD_LAT];
      if (p_vld[RD_LAT]) begin
        gb_rdata <= p_ch[RD_LAT] ? ret_ch_dat : p_dat[RD_LAT];
      end
    end
  end

endmodule

// File: tb/tb_gb_channel_router.sv
// Purpose: bench for gb_channel_router with emulated channels and a transaction-level reference model.
// Latency: expects channel strobes at T+1 and read returns at T+RD_LAT+2.
// Backpressure: none; the host issues at most one access per cycle.
module tb_gb_channel_router;
  localparam int AW     = 24;
  localparam int DW     = 32;
  localparam int NCH    = 4;
  localparam int CH_AW  = 8;
  localparam int RD_LAT = 2;

  logic              gb_clk;
  logic              gb_rst;
  logic [AW-1:0]     gb_addr;
  logic [DW-1:0]     gb_wdata;
  logic              gb_wen;
  logic              gb_rstb;
  logic [DW-1:0]     gb_rdata;
  logic              gb_rvalid;
  logic [AW-1:0]     ch_addr;
  logic [DW-1:0]     ch_wdata;
  logic [NCH-1:0]    ch_we;
  logic [NCH-1:0]    ch_rstb;
  logic [NCH*DW-1:0] ch_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  gb_channel_router dut (
    .gb_clk    (gb_clk),
    .gb_rst    (gb_rst),
    .gb_addr   (gb_addr),
    .gb_wdata  (gb_wdata),
    .gb_wen    (gb_wen),
    .gb_rstb   (gb_rstb),
    .gb_rdata  (gb_rdata),
    .gb_rvalid (gb_rvalid),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_we     (ch_we),
    .ch_rstb   (ch_rstb),
    .ch_rdata  (ch_rdata)
  );

  initial begin
    gb_clk = 1'b0;
    forever #5 gb_clk = ~gb_clk;
  end

  always @(posedge gb_clk) cyc <= cyc + 1;

  initial begin
    #20000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model state
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  ref_en;
  logic [15:0] ref_cnt;
  logic [23:0] ref_maddr;
  logic [31:0] ref_mem [NCH][256];

  function automatic logic [31:0] init_word(input int k, input int off);
    return {8'(k), 8'(off), 16'hC3A5};
  endfunction

  function automatic logic [31:0] csr_val(input logic [1:0] off);
    case (off)
      2'd0:    return {28'h0, ref_en};
      2'd1:    return {16'h0, ref_cnt};
      2'd2:    return {8'h0, ref_maddr};
      default: return {8'h47, 8'(NCH), 8'(CH_AW), 8'(RD_LAT)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel emulators: memories with a fixed RD_LAT response, junk outside the valid cycle.
  logic [31:0] emu_mem  [NCH][256];
  logic [31:0] slot_dat [NCH][4];
  bit          slot_vld [NCH][4];
  bit          emu_init = 1'b0;

  always @(negedge gb_clk) begin
    if (!emu_init) begin
      for (int k = 0; k < NCH; k++)
        for (int o = 0; o < 256; o++)
          emu_mem[k][o] = init_word(k, o);
      emu_init = 1'b1;
    end
    for (int k = 0; k < NCH; k++) begin
      if (ch_we[k]) emu_mem[k][ch_addr[7:0]] = ch_wdata;
      if (ch_rstb[k]) begin
        slot_dat[k][(cyc + RD_LAT) % 4] = emu_mem[k][ch_addr[7:0]];
        slot_vld[k][(cyc + RD_LAT) % 4] = 1'b1;
      end
      if (slot_vld[k][cyc % 4]) begin
        ch_rdata[k*DW +: DW] = slot_dat[k][cyc % 4];
        slot_vld[k][cyc % 4] = 1'b0;
      end else begin
        ch_rdata[k*DW +: DW] = 32'hBAD0_0000 | 32'(k);
      end
    end
  end

  // Return monitor: every expected read must show up exactly on its due cycle.
  always @(negedge gb_clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("gb_rvalid", 64'(gb_rvalid), 64'(1'b1));
      chk("gb_rdata", 64'(gb_rdata), 64'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      chk("gb_rvalid_idle", 64'(gb_rvalid), 64'(1'b0));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge gb_clk);
    #1;
  endtask

  // One host access: update the model, drive for one cycle, check the issue stage at T+1.
  task automatic access(input logic wen, input logic rstb, input logic [23:0] addr,
                        input logic [31:0] wdata);
    logic           wr, rd, is_loc, is_ch;
    int             win, k;
    logic [NCH-1:0] exp_we, exp_rstb;
    exp_t           e;
    wr     = wen;
    rd     = rstb && !wen;
    win    = int'(addr[23:8]);
    k      = win - 1;
    is_loc = (addr[23:2] == 22'd0);
    is_ch  = 1'b0;
    if (win >= 1 && win <= NCH) is_ch = ref_en[k];
    exp_we   = '0;
    exp_rstb = '0;
    if (is_ch && wr) exp_we[k] = 1'b1;
    if (is_ch && rd) exp_rstb[k] = 1'b1;
    if (rd) begin
      if (is_ch)       e.data = ref_mem[k][addr[7:0]];
      else if (is_loc) e.data = csr_val(addr[1:0]);
      else             e.data = 32'hDEADBEEF;
      e.due = cyc + RD_LAT + 2;
      exp_q.push_back(e);
    end
    if (wr && is_ch) ref_mem[k][addr[7:0]] = wdata;
    if (wr && is_loc && addr[1:0] == 2'd0) ref_en = wdata[3:0];
    if (wr && is_loc && addr[1:0] == 2'd1) ref_cnt = 16'h0;
    else if ((wen || rstb) && !is_ch && !is_loc) begin
      if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
      ref_maddr = addr;
    end
    gb_addr  = addr;
    gb_wdata = wdata;
    gb_wen   = wen;
    gb_rstb  = rstb;
    @(posedge gb_clk);
    #1;
    gb_wen  = 1'b0;
    gb_rstb = 1'b0;
    chk("ch_we", 64'(ch_we), 64'(exp_we));
    chk("ch_rstb", 64'(ch_rstb), 64'(exp_rstb));
    if (wen || rstb) chk("ch_addr", 64'(ch_addr), {56'h0, addr[7:0]});
    if (wen) chk("ch_wdata", 64'(ch_wdata), 64'(wdata));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ch_we"},     64'(ch_we),     64'h0);
    chk({tag, "_ch_rstb"},   64'(ch_rstb),   64'h0);
    chk({tag, "_gb_rvalid"}, 64'(gb_rvalid), 64'h0);
    chk({tag, "_gb_rdata"},  64'(gb_rdata),  64'h0);
    chk({tag, "_ch_addr"},   64'(ch_addr),   64'h0);
    chk({tag, "_ch_wdata"},  64'(ch_wdata),  64'h0);
  endtask

  initial begin
    gb_rst   = 1'b1;
    gb_wen   = 1'b0;
    gb_rstb  = 1'b0;
    gb_addr  = '0;
    gb_wdata = '0;
    ref_en    = 4'hF;
    ref_cnt   = 16'h0;
    ref_maddr = 24'h0;
    for (int k = 0; k < NCH; k++)
      for (int o = 0; o < 256; o++)
        ref_mem[k][o] = init_word(k, o);

    repeat (3) @(posedge gb_clk);
    #1;
    check_all_zero("reset");
    gb_rst = 1'b0;

    // CSR reset values
    access(1'b0, 1'b1, 24'h000000, 32'h0);
    access(1'b0, 1'b1, 24'h000001, 32'h0);
    access(1'b0, 1'b1, 24'h000002, 32'h0);
    access(1'b0, 1'b1, 24'h000003, 32'h0);
    idle(6);

    // Channel write then read
    access(1'b1, 1'b0, 24'h000234, 32'hA5A5_0001);
    access(1'b0, 1'b1, 24'h000234, $urandom);
    idle(6);

    // Back-to-back reads: ch0, ch3, ch2, local ID
    access(1'b0, 1'b1, 24'h000110, $urandom);
    access(1'b0, 1'b1, 24'h000477, $urandom);
    access(1'b0, 1'b1, 24'h0003C0, $urandom);
    access(1'b0, 1'b1, 24'h000003, $urandom);
    idle(6);

    // Disabled channel 2
    access(1'b1, 1'b0, 24'h000000, 32'h0000_000B);
    access(1'b0, 1'b1, 24'h000300, 32'h0);
    access(1'b0, 1'b1, 24'h000001, 32'h0);
    access(1'b0, 1'b1, 24'h000002, 32'h0);
    access(1'b0, 1'b1, 24'h000000, 32'h0);
    idle(6);
    access(1'b1, 1'b0, 24'h000000, 32'h0000_000F);

    // Simultaneous strobes to channel 2: write only
    access(1'b1, 1'b1, 24'h000344, 32'h1234_5678);
    idle(6);
    access(1'b0, 1'b1, 24'h000344, 32'h0);
    idle(6);

    // Enable cleared while a read to channel 0 is in flight
    access(1'b0, 1'b1, 24'h000120, 32'h0);
    access(1'b1, 1'b0, 24'h000000, 32'h0);
    idle(6);
    access(1'b1, 1'b0, 24'h000000, 32'h0000_000F);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [23:0] a;
      logic        w, r;
      int          kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) a = {22'h0, 2'($urandom_range(0, 3))};
      else          a = {8'h0, 8'($urandom_range(0, 6)), 8'($urandom)};
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      if (kind == 9) idle(1);
      access(w, r, a, $urandom);
    end
    idle(6);

    // Saturation then clear
    for (int i = 0; i < 70000; i++)
      access(1'b1, 1'b0, {16'h00F0, 8'($urandom)}, $urandom);
    access(1'b0, 1'b1, 24'h000001, 32'h0);
    access(1'b0, 1'b1, 24'h000002, 32'h0);
    idle(6);
    access(1'b1, 1'b0, 24'h000001, 32'h0);
    access(1'b0, 1'b1, 24'h000001, 32'h0);
    idle(6);

    // Reset at T+2 of a read, with a channel write strobe that must be ignored
    access(1'b0, 1'b1, 24'h000234, 32'h0);
    @(posedge gb_clk);
    #1;
    gb_rst   = 1'b1;
    gb_wen   = 1'b1;
    gb_addr  = 24'h000201;
    gb_wdata = 32'hFFFF_0000;
    exp_q.delete();
    ref_en    = 4'hF;
    ref_cnt   = 16'h0;
    ref_maddr = 24'h0;
    @(posedge gb_clk);
    #1;
    gb_wen = 1'b0;
    check_all_zero("midreset");
    gb_rst = 1'b0;
    idle(6);
    access(1'b0, 1'b1, 24'h000000, 32'h0);
    access(1'b0, 1'b1, 24'h000001, 32'h0);
    access(1'b0, 1'b1, 24'h000201, 32'h0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_channel_router.md
# gb_channel_router

Parametrised, pipelined ghostbus fan-out stage. It decodes one host ghostbus into NCH equal-size channel windows, registers the write and read-strobe paths, and realigns channel read data into a single `gb_rdata`/`gb_rvalid` return stream with fixed latency. It also holds a small local CSR bank for channel enables and miss diagnostics. It sits between a ghostbus driver and a generate-for array of submodules or external modules, replacing per-copy hand decode.

## Interface

- `AW`, 24: address width.
- `DW`, 32: data width; must be >= 32.
- `NCH`, 4: number of channels, >= 1.
- `CH_AW`, 8: per-channel window address width; window size is 2^CH_AW.
- `BASE`, 24'h000100: channel 0 base; aligned to 2^CH_AW.
- `LOCAL_BASE`, 24'h000000: base of the 4-word local CSR bank; aligned to 4; must not overlap any channel window.
- `RD_LAT`, 2: channel read latency in cycles from `ch_rstb` to valid `ch_rdata`; >= 0.
- `MISS_DATA`, 32'hDEADBEEF: read data returned on a miss.

Ports:

- `gb_clk`, in, 1: sole clock; all logic is on the rising edge.
- `gb_rst`, in, 1: reset; synchronous, active-high.
- `gb_addr`, in, AW: host address.
- `gb_wdata`, in, DW: host write data.
- `gb_wen`, in, 1: write strobe, single cycle.
- `gb_rstb`, in, 1: read strobe, single cycle.
- `gb_rdata`, out, DW: read return data.
- `gb_rvalid`, out, 1: one-cycle pulse qualifying `gb_rdata`.
- `ch_addr`, out, AW: relative address `{0, gb_addr[CH_AW-1:0]}`, registered, shared by all channels.
- `ch_wdata`, out, DW: registered write data, shared by all channels.
- `ch_we`, out, NCH: per-channel write strobe.
- `ch_rstb`, out, NCH: per-channel read strobe.
- `ch_rdata`, in, NCH*DW: channel k occupies bits [(k+1)*DW-1 -: DW].

## Operation

- **Channel hit.** Channel k is hit when `gb_addr[AW-1:CH_AW] == BASE[AW-1:CH_AW] + k` and `ch_en[k] == 1`.
- **Local hit.** A local access is one where `gb_addr[AW-1:2] == LOCAL_BASE[AW-1:2]`.
- **Miss.** Any access that is neither a channel hit nor a local hit is a miss. An address in a disabled channel's window is a miss.
- **Issue stage.** The issue stage registers `gb_addr`, `gb_wdata`, the hit one-hot and the op. In the next cycle it drives `ch_addr`, `ch_wdata`, and a one-cycle `ch_we[k]` or `ch_rstb[k]`. Addr and wdata hold their value until the next strobe.
- **Simultaneous strobes.** If `gb_wen` and `gb_rstb` are both high, the access is a write only. The read is dropped, and no `gb_rvalid` is produced.
- **Read return pipeline.** A shift register of depth RD_LAT+1 carries {valid, hit index, local/miss tag, local data snapshot}. The stage that meets the channel's data-valid cycle captures `ch_rdata[k]`. Output registers then drive `gb_rdata`/`gb_rvalid`. One read per cycle is sustained, with no stalls.
- **Uniform latency.** Local and miss reads travel through the same pipeline, so every read returns with identical latency and in issue order.
- **Local CSRs** (word offset from LOCAL_BASE; data is zero-extended to DW):
  - 0, CTRL: `ch_en[NCH-1:0]`, read/write; reset is all ones.
  - 1, MISS_CNT: 16-bit counter, read-only, saturating. Any write to this offset clears it.
  - 2, MISS_ADDR: AW bits, read-only; the address of the most recent miss.
  - 3, ID: read-only; `{8'h47, NCH[7:0], CH_AW[7:0], RD_LAT[7:0]}`.
- **Local read snapshot.** Local read data is snapshotted in the issue cycle, so a local read reflects all writes that completed earlier.
- **Miss handling.**
  - A miss write is dropped.
  - A miss read returns MISS_DATA.
  - Every miss increments MISS_CNT; the count holds at 16'hFFFF.
  - A miss updates MISS_ADDR.
  - If a MISS_CNT clear and a miss occur in the same cycle, the clear wins and the count is 0.
- **Mid-flight enable change.** Clearing `ch_en[k]` while a read to k is in flight does not cancel that read; it still returns `ch_rdata[k]`.

## Timing

- The host strobe is at cycle T.
- `ch_we`/`ch_rstb` are asserted at T+1.
- Channel data is valid at T+1+RD_LAT.
- `gb_rvalid` is asserted at T+RD_LAT+2.
- With the default RD_LAT=2, read latency is 4 cycles.
- Write side effects:
  - Local CSR writes take effect at T+1.
  - Channel writes take effect at the channel's own edge, at T+1 or later.
- `gb_rst` asserted at any edge has these effects:
  - `ch_we`, `ch_rstb`, `gb_rvalid` go to 0, and `gb_rdata`, `ch_addr`, `ch_wdata` go to 0.
  - The pipeline is flushed; no `gb_rvalid` follows for reads in flight.
  - `ch_en` is set to all ones, and MISS_CNT and MISS_ADDR go to 0.
- Strobes that arrive while `gb_rst` is high are ignored.

## Test plan

- **Channel write then read.** Write 32'hA5A5_0001 to 0x000234 (channel 1, offset 0x34).
  - Required: `ch_we` = 4'b0010 and `ch_addr` = 0x34 at T+1.
  - Required: a read of the same address gives `gb_rvalid` at T+4 with the channel's returned data.
- **Back-to-back reads.** Issue reads to channels 0, 3, 2, local ID on consecutive cycles.
  - Required: four consecutive `gb_rvalid` pulses in order, the last being 32'h4704_0802.
- **Disabled channel.** Write CTRL = 4'b1011, then read 0x000300.
  - Required: no `ch_rstb`, `gb_rdata` = 32'hDEADBEEF, MISS_CNT = 1, MISS_ADDR = 0x000300.
- **Saturation and clear.**
  - 70000 miss writes: MISS_CNT reads 0xFFFF.
  - A write to MISS_CNT in the same cycle as a miss: MISS_CNT reads 0.
- **Simultaneous strobes.** Assert `gb_wen` and `gb_rstb` together to channel 2.
  - Required: `ch_we` = 4'b0100, `ch_rstb` = 0, and no `gb_rvalid`.
- **Reset mid-read.** Assert `gb_rst` at T+2 of a read.
  - Required: no `gb_rvalid` for that read, all outputs 0, CTRL reads 4'b1111.
